// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, bounds in-flight imem requests and tracks
// instruction-buffer credits. Optional perf counters are enabled by FETCH_CTRL_PERF_EN.
module fetch_ctrl #(
    parameter int                     CPU_ADDR_BITS     = 32,
    parameter int                     FETCH_WIDTH       = 2,
    parameter int                     INST_BUFFER_DEPTH = 8,
    parameter logic [CPU_ADDR_BITS-1:0] RESET_PC        = '0,
    parameter int                     MAX_INFLIGHT      = 4,
    parameter int                     BUF_DEPTH         = INST_BUFFER_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               redirect_val,
    input  logic [CPU_ADDR_BITS-1:0]           redirect_pc,
    output logic                               imem_req_val,
    output logic [CPU_ADDR_BITS-1:0]           imem_req_addr,
    input  logic                               imem_req_rdy,
    input  logic                               imem_resp_val,
    output logic                               buf_wr_val,
    output logic [CPU_ADDR_BITS-1:0]           buf_wr_pc,
    input  logic                               buf_deq,
    output logic                               buf_flush,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]  inflight_cnt,
    output logic [31:0]                        perf_issued,
    output logic [31:0]                        perf_dropped
);

    localparam int CNT_W  = $clog2(MAX_INFLIGHT + 1);
    localparam int PTR_W  = $clog2(MAX_INFLIGHT);
    localparam int CRED_W = $clog2(BUF_DEPTH);

    localparam logic [CRED_W-1:0]        CRED_MAX   = CRED_W'(BUF_DEPTH - 1);
    localparam logic [CNT_W-1:0]         INF_MAX    = CNT_W'(MAX_INFLIGHT);
    localparam logic [CPU_ADDR_BITS-1:0] PC_STEP    = CPU_ADDR_BITS'(4 * FETCH_WIDTH);
    localparam logic [CPU_ADDR_BITS-1:0] ALIGN_MASK = CPU_ADDR_BITS'(3);

    // r_run stays low for the first cycle after reset release so outputs are quiet
    // during reset and the first request appears one cycle after release.
    logic                     r_run;
    logic [CPU_ADDR_BITS-1:0] r_fetch_pc;
    logic [CRED_W-1:0]        r_credits;
    logic [CNT_W-1:0]         r_inflight;
    logic [PTR_W-1:0]         r_head;
    logic [PTR_W-1:0]         r_tail;
    logic [CPU_ADDR_BITS-1:0] r_q_pc   [MAX_INFLIGHT];
    logic                     r_q_live [MAX_INFLIGHT];

    logic                     w_issue_ok;
    logic                     w_accept;
    logic                     w_pop;
    logic                     w_redirect;
    logic                     w_deq;
    logic                     w_head_live;
    logic                     w_wr_val;
    logic [CPU_ADDR_BITS-1:0] w_head_pc;
    logic [CPU_ADDR_BITS-1:0] w_redirect_target;
    logic [CRED_W-1:0]        w_credits_next;
    logic [CNT_W-1:0]         w_inflight_next;
    logic [MAX_INFLIGHT-1:0]  w_push_sel;

    assign w_issue_ok = r_run && !redirect_val && (r_credits != '0) && (r_inflight != INF_MAX);
    assign w_accept   = w_issue_ok && imem_req_rdy;
    // A response with nothing outstanding is a protocol violation and is ignored.
    assign w_pop      = r_run && imem_resp_val && (r_inflight != '0);
    assign w_redirect = r_run && redirect_val;
    assign w_deq      = r_run && buf_deq && !redirect_val;

    assign w_head_pc         = r_q_pc[r_head];
    assign w_head_live       = r_q_live[r_head];
    assign w_wr_val          = w_pop && w_head_live && !redirect_val;
    assign w_redirect_target = redirect_pc & ~ALIGN_MASK;

    assign imem_req_val  = w_issue_ok;
    assign imem_req_addr = r_run ? r_fetch_pc : '0;
    assign buf_wr_val    = w_wr_val;
    assign buf_wr_pc     = w_wr_val ? w_head_pc : '0;
    assign buf_flush     = w_redirect;
    assign inflight_cnt  = r_inflight;

    always_comb begin
        w_credits_next = r_credits;
        if (w_redirect) begin
            w_credits_next = CRED_MAX;
        end else if (w_accept && !w_deq) begin
            w_credits_next = r_credits - CRED_W'(1);
        end else if (!w_accept && w_deq && (r_credits != CRED_MAX)) begin
            w_credits_next = r_credits + CRED_W'(1);
        end
    end

    always_comb begin
        w_inflight_next = r_inflight;
        if (w_accept && !w_pop) begin
            w_inflight_next = r_inflight + CNT_W'(1);
        end else if (!w_accept && w_pop) begin
            w_inflight_next = r_inflight - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run      <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_credits  <= CRED_MAX;
            r_inflight <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            r_run      <= 1'b1;
            r_credits  <= w_credits_next;
            r_inflight <= w_inflight_next;
            if (w_redirect) begin
                r_fetch_pc <= w_redirect_target;
            end else if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + PC_STEP;
            end
            // Pointers wrap naturally because MAX_INFLIGHT is a power of two.
            if (w_accept) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < MAX_INFLIGHT; gi++) begin : g_tag_q
            assign w_push_sel[gi] = w_accept && (r_tail == PTR_W'(gi));

            // Redirect only clears the live bit; stale entries drain through their responses.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q_pc[gi]   <= '0;
                    r_q_live[gi] <= 1'b0;
                end else if (w_redirect) begin
                    r_q_live[gi] <= 1'b0;
                end else if (w_push_sel[gi]) begin
                    r_q_pc[gi]   <= r_fetch_pc;
                    r_q_live[gi] <= 1'b1;
                end
            end
        end
    endgenerate

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] r_perf_issued;
    logic [31:0] r_perf_dropped;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_issued  <= '0;
            r_perf_dropped <= '0;
        end else begin
            if (w_accept) begin
                r_perf_issued <= r_perf_issued + 32'd1;
            end
            if (w_pop && !w_wr_val) begin
                r_perf_dropped <= r_perf_dropped + 32'd1;
            end
        end
    end

    assign perf_issued  = r_perf_issued;
    assign perf_dropped = r_perf_dropped;
`else
    assign perf_issued  = '0;
    assign perf_dropped = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed scenarios plus randomized traffic checked
// against a queue-based reference model; a second instance covers a 4-deep buffer.
module tb_fetch_ctrl;

    localparam int          MI  = 4;
    localparam int          D   = 8;
    localparam logic [31:0] RPC = 32'h0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, redirect_val, imem_req_rdy, imem_resp_val, buf_deq;
    logic [31:0] redirect_pc;
    logic        imem_req_val, buf_wr_val, buf_flush;
    logic [31:0] imem_req_addr, buf_wr_pc, perf_issued, perf_dropped;
    logic [2:0]  inflight_cnt;

    logic        b_rst_n, b_redir, b_rdy, b_resp, b_deq;
    logic [31:0] b_rpc;
    logic        b_req_val, b_wr_val, b_flush;
    logic [31:0] b_req_addr, b_wr_pc, b_perf_i, b_perf_d;
    logic [2:0]  b_inflight;

    fetch_ctrl #(.CPU_ADDR_BITS(32), .FETCH_WIDTH(2), .INST_BUFFER_DEPTH(D), .RESET_PC(RPC),
                 .MAX_INFLIGHT(MI), .BUF_DEPTH(D)) u_dut (
        .clk(clk), .rst_n(rst_n), .redirect_val(redirect_val), .redirect_pc(redirect_pc),
        .imem_req_val(imem_req_val), .imem_req_addr(imem_req_addr), .imem_req_rdy(imem_req_rdy),
        .imem_resp_val(imem_resp_val), .buf_wr_val(buf_wr_val), .buf_wr_pc(buf_wr_pc),
        .buf_deq(buf_deq), .buf_flush(buf_flush), .inflight_cnt(inflight_cnt),
        .perf_issued(perf_issued), .perf_dropped(perf_dropped)
    );

    fetch_ctrl #(.CPU_ADDR_BITS(32), .FETCH_WIDTH(2), .INST_BUFFER_DEPTH(4), .RESET_PC(RPC),
                 .MAX_INFLIGHT(MI), .BUF_DEPTH(4)) u_dut4 (
        .clk(clk), .rst_n(b_rst_n), .redirect_val(b_redir), .redirect_pc(b_rpc),
        .imem_req_val(b_req_val), .imem_req_addr(b_req_addr), .imem_req_rdy(b_rdy),
        .imem_resp_val(b_resp), .buf_wr_val(b_wr_val), .buf_wr_pc(b_wr_pc),
        .buf_deq(b_deq), .buf_flush(b_flush), .inflight_cnt(b_inflight),
        .perf_issued(b_perf_i), .perf_dropped(b_perf_d)
    );

    typedef struct {
        logic [31:0] pc;
        bit          live;
    } ent_t;

    ent_t        q[$];
    bit          m_run;
    logic [31:0] m_pc;
    int          m_cred;
    logic [31:0] m_issued, m_dropped;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_run     = 1'b0;
        m_pc      = RPC;
        m_cred    = D - 1;
        q.delete();
        m_issued  = '0;
        m_dropped = '0;
    endfunction

    function automatic bit m_req_val();
        return m_run && rst_n && !redirect_val && (m_cred != 0) && (q.size() != MI);
    endfunction

    task automatic check_outputs();
        bit          wv;
        logic [31:0] wpc;
        wv  = 1'b0;
        wpc = '0;
        if (m_run && imem_resp_val && !redirect_val && q.size() > 0) begin
            if (q[0].live) begin
                wv  = 1'b1;
                wpc = q[0].pc;
            end
        end
        chk("req_val", 32'(imem_req_val), 32'(m_req_val()));
        chk("req_addr", imem_req_addr, m_run ? m_pc : 32'h0);
        chk("wr_val", 32'(buf_wr_val), 32'(wv));
        chk("wr_pc", buf_wr_pc, wpc);
        chk("flush", 32'(buf_flush), 32'(m_run && redirect_val));
        chk("inflight", 32'(inflight_cnt), 32'(q.size()));
`ifdef FETCH_CTRL_PERF_EN
        chk("perf_issued", perf_issued, m_issued);
        chk("perf_dropped", perf_dropped, m_dropped);
`else
        chk("perf_issued", perf_issued, 32'h0);
        chk("perf_dropped", perf_dropped, 32'h0);
`endif
    endtask

    // One clock: settle, compare against the model, advance across the edge.
    task automatic step();
        bit   acc;
        ent_t e;
        #1;
        check_outputs();
        acc = m_req_val() && imem_req_rdy;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (m_run) begin
                if (imem_resp_val && q.size() > 0) begin
                    e = q.pop_front();
                    if (!e.live || redirect_val) m_dropped = m_dropped + 1;
                end
                if (redirect_val) begin
                    foreach (q[i]) q[i].live = 1'b0;
                    m_pc   = redirect_pc & 32'hFFFF_FFFC;
                    m_cred = D - 1;
                end else begin
                    if (acc) begin
                        q.push_back('{pc: m_pc, live: 1'b1});
                        m_pc     = m_pc + 32'd8;
                        m_issued = m_issued + 1;
                    end
                    m_cred = m_cred - int'(acc) + int'(buf_deq);
                    if (m_cred > D - 1) m_cred = D - 1;
                end
            end
            m_run = 1'b1;
        end
        #1;
    endtask

    task automatic drain();
        imem_req_rdy = 1'b0; redirect_val = 1'b0; buf_deq = 1'b0;
        for (int k = 0; k < 20 && q.size() > 0; k++) begin
            imem_resp_val = 1'b1;
            step();
        end
        imem_resp_val = 1'b0;
    endtask

    initial begin
        int          cnt;
        int          bout;
        int          cyc;
        bit          a;
        int          pend[$];
        logic [31:0] got[$];

        rst_n = 1'b0; redirect_val = 1'b0; redirect_pc = '0; imem_req_rdy = 1'b1;
        imem_resp_val = 1'b0; buf_deq = 1'b0;
        b_rst_n = 1'b0; b_redir = 1'b0; b_rpc = '0; b_rdy = 1'b0; b_resp = 1'b0; b_deq = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Credit limit on the 4-deep instance: on-time responses, no dequeues.
        b_rst_n = 1'b1; b_rdy = 1'b1;
        cnt = 0; bout = 0;
        for (int c = 0; c < 12; c++) begin
            b_resp = (bout > 0);
            #1;
            a = b_req_val && b_rdy;
            @(posedge clk); #1;
            bout = bout + int'(a) - int'(b_resp);
            cnt  = cnt + int'(a);
        end
        b_resp = 1'b0;
        chk("b_accepts", 32'(cnt), 32'd3);
        b_deq = 1'b1;
        #1;
        chk("b_deq_cycle_val", 32'(b_req_val), 32'd0);
        @(posedge clk); #1;
        b_deq = 1'b0;
        #1;
        chk("b_after_deq_val", 32'(b_req_val), 32'd1);
        chk("b_after_deq_addr", b_req_addr, 32'h18);
        @(posedge clk); #1;
        chk("b_held_val", 32'(b_req_val), 32'd0);

        // Reset: quiet outputs while held, then requests at 0x0..0x18.
        step(); step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rst_seq_val", 32'(imem_req_val), 32'd1);
            chk("rst_seq_addr", imem_req_addr, 32'(8 * i));
            step();
        end
        #1;
        chk("rst_full_val", 32'(imem_req_val), 32'd0);
        chk("rst_full_inflight", 32'(inflight_cnt), 32'd4);

        // Mid-operation reset with two requests outstanding.
        imem_req_rdy = 1'b0; imem_resp_val = 1'b1;
        step(); step();
        imem_resp_val = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst_val", 32'(imem_req_val), 32'd0);
        chk("mrst_inflight", 32'(inflight_cnt), 32'd0);
        model_reset();
        step(); step();
        rst_n = 1'b1; imem_req_rdy = 1'b1;
        step();
        #1;
        chk("mrst_restart_val", 32'(imem_req_val), 32'd1);
        chk("mrst_restart_addr", imem_req_addr, RPC);
        step(); step(); step();

        // Redirect with three requests outstanding.
        redirect_val = 1'b1; redirect_pc = 32'h1000;
        #1;
        chk("redir_flush", 32'(buf_flush), 32'd1);
        chk("redir_noissue", 32'(imem_req_val), 32'd0);
        step();
        redirect_val = 1'b0;
        #1;
        chk("redir_target_addr", imem_req_addr, 32'h1000);
        chk("redir_target_val", 32'(imem_req_val), 32'd1);
        step();
        imem_req_rdy = 1'b0; imem_resp_val = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("redir_resp_val", 32'(buf_wr_val), (k < 3) ? 32'd0 : 32'd1);
            if (k == 3) chk("redir_resp_pc", buf_wr_pc, 32'h1000);
            step();
        end
        imem_resp_val = 1'b0;
        #1;
`ifdef FETCH_CTRL_PERF_EN
        chk("redir_dropped", perf_dropped, 32'd3);
`else
        chk("redir_dropped", perf_dropped, 32'd0);
`endif

        // Redirect, live response and dequeue in one cycle.
        imem_req_rdy = 1'b1;
        step();
        imem_req_rdy = 1'b0;
        redirect_val = 1'b1; redirect_pc = 32'h2000; imem_resp_val = 1'b1; buf_deq = 1'b1;
        #1;
        chk("simul_wr_val", 32'(buf_wr_val), 32'd0);
        chk("simul_flush", 32'(buf_flush), 32'd1);
        step();
        redirect_val = 1'b0; imem_resp_val = 1'b0; buf_deq = 1'b0;
        imem_req_rdy = 1'b1; cnt = 0;
        for (int k = 0; k < 14; k++) begin
            imem_resp_val = (q.size() > 0);
            #1;
            cnt = cnt + int'(imem_req_val && imem_req_rdy);
            step();
        end
        chk("simul_credits", 32'(cnt), 32'(D - 1));
        drain();

        // Tag-queue wrap: 2*MI+1 requests with two-cycle imem latency.
        redirect_val = 1'b1; redirect_pc = 32'h4000;
        step();
        redirect_val = 1'b0; buf_deq = 1'b1;
        cnt = 0; cyc = 0;
        for (int k = 0; k < 60 && got.size() < 2 * MI + 1; k++) begin
            imem_req_rdy  = (cnt < 2 * MI + 1);
            imem_resp_val = (pend.size() > 0) && (cyc - pend[0] >= 2);
            #1;
            if (imem_req_val && imem_req_rdy) begin
                pend.push_back(cyc);
                cnt++;
            end
            if (imem_resp_val) void'(pend.pop_front());
            if (buf_wr_val) got.push_back(buf_wr_pc);
            step();
            cyc++;
        end
        chk("wrap_count", 32'(got.size()), 32'(2 * MI + 1));
        foreach (got[i]) chk("wrap_pc", got[i], 32'h4000 + 32'(8 * i));
        drain();

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            imem_req_rdy  = ($urandom_range(0, 3) != 0);
            if (q.size() > 0) imem_resp_val = ($urandom_range(0, 2) != 0);
            else              imem_resp_val = ($urandom_range(0, 19) == 0);
            buf_deq      = ($urandom_range(0, 1) == 1);
            redirect_val = ($urandom_range(0, 29) == 0);
            redirect_pc  = $urandom();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
